// File: rtl/digit_sched_pkg.sv
//==============================================================================
// Package : digit_sched_pkg
// Brief   : Shared FSM states, glyph codes and one-hot digit selects for the
//           digit scan scheduler.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package digit_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] NUMBER_BLANK = 4'd12;

    localparam logic [3:0] DIG3 = 4'd8;
    localparam logic [3:0] DIG2 = 4'd4;
    localparam logic [3:0] DIG1 = 4'd2;
    localparam logic [3:0] DIG0 = 4'd1;

    localparam int DEFAULT_DIGIT_PITCH = 9;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker: first request at or above the
//           pointer, wrapping around; pointer register lives in the parent.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/digit_scan_scheduler.sv
//==============================================================================
// Module  : digit_scan_scheduler
// Brief   : Time-shares one 4-bit binary digit renderer among display fields,
//           scanning digits MSB-first with a fixed hold per digit.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module digit_scan_scheduler
    import digit_sched_pkg::*;
#(
    parameter int N_FIELDS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int DIGIT_PITCH = DEFAULT_DIGIT_PITCH
) (
    input  logic                     F25MHZ,
    input  logic                     RESET,
    input  logic [N_FIELDS-1:0]      REQ,
    input  logic [4*N_FIELDS-1:0]    FIELD_DATA,
    input  logic [10*N_FIELDS-1:0]   FIELD_X,
    input  logic [10*N_FIELDS-1:0]   FIELD_Y,
    output logic [N_FIELDS-1:0]      GNT,
    output logic [N_FIELDS-1:0]      DONE,
    output logic [3:0]               DIGIT,
    output logic [9:0]               DIGIT_LOW_X,
    output logic [9:0]               DIGIT_LOW_Y,
    output logic [3:0]               NUMBER,
    output logic                     BUSY
);

    localparam int IW       = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int HW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

    localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD_EFF - 1);
    localparam logic [IW-1:0] c_WIN_LAST  = IW'(N_FIELDS - 1);
    localparam logic [9:0]    c_PITCH     = 10'(DIGIT_PITCH);

    state_t              r_state_q,  w_state_d;
    logic [IW-1:0]       r_ptr_q,    w_ptr_d;
    logic [IW-1:0]       r_win_q,    w_win_d;
    logic [N_FIELDS-1:0] r_gnt_q,    w_gnt_d;
    logic [N_FIELDS-1:0] r_done_q,   w_done_d;
    logic [3:0]          r_data_q,   w_data_d;
    logic [1:0]          r_k_q,      w_k_d;
    logic [HW-1:0]       r_hold_q,   w_hold_d;
    logic [3:0]          r_digit_q,  w_digit_d;
    logic [3:0]          r_number_q, w_number_d;
    logic [9:0]          r_low_x_q,  w_low_x_d;
    logic [9:0]          r_low_y_q,  w_low_y_d;
    logic                r_busy_q,   w_busy_d;

    logic [N_FIELDS-1:0] w_grant;
    logic [IW-1:0]       w_win_idx;
    int                  w_win_int;

    rr_arbiter #(
        .N  (N_FIELDS),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req   (REQ),
        .i_ptr   (r_ptr_q),
        .o_grant (w_grant)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (w_grant[i]) begin
                w_win_idx = IW'(i);
            end
        end
    end

    assign w_win_int = int'(r_win_q);

    always_comb begin
        w_state_d  = r_state_q;
        w_ptr_d    = r_ptr_q;
        w_win_d    = r_win_q;
        w_gnt_d    = r_gnt_q;
        w_done_d   = r_done_q;
        w_data_d   = r_data_q;
        w_k_d      = r_k_q;
        w_hold_d   = r_hold_q;
        w_digit_d  = r_digit_q;
        w_number_d = r_number_q;
        w_low_x_d  = r_low_x_q;
        w_low_y_d  = r_low_y_q;

        unique case (r_state_q)
            IDLE: begin
                if (|REQ) begin
                    w_state_d = LOAD;
                    w_win_d   = w_win_idx;
                    w_gnt_d   = w_grant;
                end
            end
            // The first digit's outputs are loaded alongside the snapshot so
            // DRAW opens with valid glyph data on its very first cycle.
            LOAD: begin
                w_data_d   = FIELD_DATA[4*w_win_int +: 4];
                w_low_x_d  = FIELD_X[10*w_win_int +: 10];
                w_low_y_d  = FIELD_Y[10*w_win_int +: 10];
                w_digit_d  = DIG3;
                w_number_d = {3'b000, FIELD_DATA[4*w_win_int + 3]};
                w_k_d      = 2'd3;
                w_hold_d   = '0;
                w_state_d  = DRAW;
            end
            DRAW: begin
                if (r_hold_q == c_HOLD_LAST) begin
                    w_hold_d = '0;
                    if (r_k_q == 2'd0) begin
                        w_state_d  = FINISH;
                        w_digit_d  = 4'd0;
                        w_number_d = NUMBER_BLANK;
                        w_done_d   = r_gnt_q;
                    end else begin
                        w_k_d      = r_k_q - 2'd1;
                        w_digit_d  = r_digit_q >> 1;
                        w_number_d = {3'b000, r_data_q[r_k_q - 2'd1]};
                        w_low_x_d  = r_low_x_q + c_PITCH;
                    end
                end else begin
                    w_hold_d = r_hold_q + 1'b1;
                end
            end
            FINISH: begin
                w_done_d  = '0;
                w_gnt_d   = '0;
                w_ptr_d   = (r_win_q == c_WIN_LAST) ? '0 : r_win_q + 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge F25MHZ) begin
        if (RESET) begin
            r_state_q  <= IDLE;
            r_ptr_q    <= '0;
            r_win_q    <= '0;
            r_gnt_q    <= '0;
            r_done_q   <= '0;
            r_data_q   <= '0;
            r_k_q      <= '0;
            r_hold_q   <= '0;
            r_digit_q  <= '0;
            r_number_q <= NUMBER_BLANK;
            r_low_x_q  <= '0;
            r_low_y_q  <= '0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_ptr_q    <= w_ptr_d;
            r_win_q    <= w_win_d;
            r_gnt_q    <= w_gnt_d;
            r_done_q   <= w_done_d;
            r_data_q   <= w_data_d;
            r_k_q      <= w_k_d;
            r_hold_q   <= w_hold_d;
            r_digit_q  <= w_digit_d;
            r_number_q <= w_number_d;
            r_low_x_q  <= w_low_x_d;
            r_low_y_q  <= w_low_y_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign GNT         = r_gnt_q;
    assign DONE        = r_done_q;
    assign DIGIT       = r_digit_q;
    assign NUMBER      = r_number_q;
    assign DIGIT_LOW_X = r_low_x_q;
    assign DIGIT_LOW_Y = r_low_y_q;
    assign BUSY        = r_busy_q;

endmodule

`default_nettype wire
